// File: rtl/step_controller_pkg.sv
// Shared types for the step controller: state and mode encodings, command
// pulse bundle with its priority decode, and watchdog defaults.
package step_controller_pkg;

    localparam int unsigned DEF_STEP_CNT_W  = 8;
    localparam int unsigned DEF_WDOG_W      = 16;
    localparam int unsigned DEF_WDOG_LIMIT  = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALTED = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_TCK  = 2'd0,
        MODE_SXR  = 2'd1,
        MODE_TEST = 2'd2
    } exec_mode_t;

    // Raw one-cycle command pulses from the decoder
    typedef struct packed {
        logic abort;
        logic clear;
        logic halt;
        logic test;
        logic sxr;
        logic tck;
    } cmd_pulses_t;

    typedef enum logic [2:0] {
        CMD_NONE        = 3'd0,
        CMD_CLEAR_ABORT = 3'd1,
        CMD_ABORT       = 3'd2,
        CMD_CLEAR       = 3'd3,
        CMD_HALT        = 3'd4,
        CMD_TEST        = 3'd5,
        CMD_SXR         = 3'd6,
        CMD_TCK         = 3'd7
    } cmd_e;

    // Reduce same-cycle pulses to the single winning command.
    // Clear+abort is kept as its own code because the decoder issues the pair.
    function automatic cmd_e decode_cmd(input cmd_pulses_t p);
        cmd_e c;
        c = CMD_NONE;
        if (p.abort && p.clear) c = CMD_CLEAR_ABORT;
        else if (p.abort)       c = CMD_ABORT;
        else if (p.clear)       c = CMD_CLEAR;
        else if (p.halt)        c = CMD_HALT;
        else if (p.test)        c = CMD_TEST;
        else if (p.sxr)         c = CMD_SXR;
        else if (p.tck)         c = CMD_TCK;
        return c;
    endfunction

endpackage

// File: rtl/step_watchdog.sv
// Handshake watchdog: counts cycles spent in CLEAR/EXEC/ABORT, restarts on
// every state entry, freezes in HALTED, and raises a sticky timeout flag.
module step_watchdog
    import step_controller_pkg::*;
#(
    parameter int unsigned WDOG_W     = DEF_WDOG_W,
    parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic   clk,
    input  logic   reset_n,
    input  state_t state,
    input  state_t state_n,
    output logic   expire_c,
    output logic   timeout_err
);

    logic [WDOG_W-1:0] cnt;
    logic              run;
    logic              entry;

    assign run      = (state == ST_CLEAR) || (state == ST_EXEC) || (state == ST_ABORT);
    assign entry    = (state_n != state);
    // Fires on the cycle whose closing edge would make the count reach the limit
    assign expire_c = run && (cnt == WDOG_W'(WDOG_LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (entry) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if (state_n == ST_CLEAR && state != ST_CLEAR) begin
            timeout_err <= 1'b0;
        end else if (expire_c) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: rtl/step_controller.sv
// Test-engine sequencer: turns decoder command pulses into clear/exec
// handshakes, with halt/resume and abort. Optional watchdog: STEP_CTRL_WATCHDOG_EN.
module step_controller
    import step_controller_pkg::*;
#(
    parameter int unsigned STEP_CNT_W = DEF_STEP_CNT_W,
    parameter int unsigned WDOG_W     = DEF_WDOG_W,
    parameter int unsigned WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  request_clear_mem,
    input  logic                  go_step_tck,
    input  logic                  go_step_sxr,
    input  logic                  go_step_test,
    input  logic                  test_halt,
    input  logic                  test_abort,
    output logic                  mem_clear_req,
    input  logic                  mem_clear_done,
    output logic                  exec_req,
    output logic [1:0]            exec_mode,
    output logic                  exec_halt,
    output logic                  exec_abort,
    input  logic                  exec_done,
    input  logic                  exec_idle,
    output logic                  step_done,
    output logic                  cmd_rejected,
    output logic                  busy,
    output logic [2:0]            state_o,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic                  timeout_err
);

    state_t                state, state_n;
    exec_mode_t            mode, mode_n;
    logic                  pending_clear, pending_clear_n;
    logic [STEP_CNT_W-1:0] count_n;
    logic                  done_n;
    logic                  rej_n;
    logic                  expire_c;
    cmd_e                  cmd;

    assign cmd = decode_cmd('{abort: test_abort, clear: request_clear_mem, halt: test_halt,
                              test: go_step_test, sxr: go_step_sxr, tck: go_step_tck});

`ifdef STEP_CTRL_WATCHDOG_EN
    step_watchdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .clk         (clk),
        .reset_n     (reset_n),
        .state       (state),
        .state_n     (state_n),
        .expire_c    (expire_c),
        .timeout_err (timeout_err)
    );
`else
    logic unused_wdog_params;
    assign unused_wdog_params = ^{WDOG_W, WDOG_LIMIT};
    assign expire_c           = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            mode          <= MODE_TCK;
            pending_clear <= 1'b0;
        end else begin
            state         <= state_n;
            mode          <= mode_n;
            pending_clear <= pending_clear_n;
        end
    end

    always_comb begin
        state_n         = state;
        mode_n          = mode;
        pending_clear_n = pending_clear;
        count_n         = step_count;
        done_n          = 1'b0;
        rej_n           = 1'b0;

        unique case (state)
            ST_IDLE: begin
                case (cmd)
                    CMD_CLEAR_ABORT,
                    CMD_CLEAR: state_n = ST_CLEAR;
                    CMD_HALT:  rej_n   = 1'b1;
                    CMD_TEST: begin
                        state_n = ST_EXEC;
                        mode_n  = MODE_TEST;
                    end
                    CMD_SXR: begin
                        state_n = ST_EXEC;
                        mode_n  = MODE_SXR;
                    end
                    CMD_TCK: begin
                        state_n = ST_EXEC;
                        mode_n  = MODE_TCK;
                    end
                    default: ;
                endcase
            end

            // A clear is never aborted; abort pulses here are simply dropped
            ST_CLEAR: begin
                if (mem_clear_done || expire_c) state_n = ST_IDLE;
                if (cmd == CMD_CLEAR || cmd == CMD_HALT || cmd == CMD_TEST ||
                    cmd == CMD_SXR || cmd == CMD_TCK) begin
                    rej_n = 1'b1;
                end
            end

            ST_EXEC: begin
                if (cmd == CMD_ABORT || cmd == CMD_CLEAR_ABORT) begin
                    state_n         = ST_ABORT;
                    pending_clear_n = (cmd == CMD_CLEAR_ABORT);
                end else if (expire_c) begin
                    state_n         = ST_ABORT;
                    pending_clear_n = 1'b0;
                end else if (exec_done) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    count_n = step_count + STEP_CNT_W'(1);
                    rej_n   = (cmd != CMD_NONE);
                end else if (cmd == CMD_HALT && mode == MODE_TEST) begin
                    state_n = ST_HALTED;
                end else begin
                    rej_n = (cmd != CMD_NONE);
                end
            end

            ST_HALTED: begin
                if (cmd == CMD_ABORT || cmd == CMD_CLEAR_ABORT) begin
                    state_n         = ST_ABORT;
                    pending_clear_n = (cmd == CMD_CLEAR_ABORT);
                end else if (exec_done) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    count_n = step_count + STEP_CNT_W'(1);
                    rej_n   = (cmd != CMD_NONE);
                end else if (cmd == CMD_TEST) begin
                    state_n = ST_EXEC;
                end else begin
                    rej_n = (cmd != CMD_NONE);
                end
            end

            // Wait for the engine to drain; a queued clear follows the abort
            ST_ABORT: begin
                if (expire_c) begin
                    state_n         = ST_IDLE;
                    pending_clear_n = 1'b0;
                end else if (exec_idle) begin
                    state_n = (pending_clear || cmd == CMD_CLEAR || cmd == CMD_CLEAR_ABORT)
                              ? ST_CLEAR : ST_IDLE;
                    pending_clear_n = 1'b0;
                end else if (cmd == CMD_CLEAR || cmd == CMD_CLEAR_ABORT) begin
                    pending_clear_n = 1'b1;
                end
                if (cmd == CMD_HALT || cmd == CMD_TEST || cmd == CMD_SXR || cmd == CMD_TCK) begin
                    rej_n = 1'b1;
                end
            end

            default: begin
                state_n         = ST_IDLE;
                pending_clear_n = 1'b0;
            end
        endcase

        if (state_n == ST_CLEAR && state != ST_CLEAR) count_n = '0;
    end

    // Outputs are registered from the next-state decode so they align with state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_clear_req <= 1'b0;
            exec_req      <= 1'b0;
            exec_mode     <= 2'd0;
            exec_halt     <= 1'b0;
            exec_abort    <= 1'b0;
            step_done     <= 1'b0;
            cmd_rejected  <= 1'b0;
            busy          <= 1'b0;
            state_o       <= 3'd0;
            step_count    <= '0;
        end else begin
            mem_clear_req <= (state_n == ST_CLEAR);
            exec_req      <= (state_n == ST_EXEC) || (state_n == ST_HALTED);
            exec_mode     <= mode_n;
            exec_halt     <= (state_n == ST_HALTED);
            exec_abort    <= (state_n == ST_ABORT);
            step_done     <= done_n;
            cmd_rejected  <= rej_n;
            busy          <= (state_n != ST_IDLE);
            state_o       <= state_n;
            step_count    <= count_n;
        end
    end

endmodule

// File: tb/tb_step_controller.sv
// Directed self-checking bench for step_controller.
module tb_step_controller;

    localparam logic [7:0] P_TCK   = 8'h01;
    localparam logic [7:0] P_SXR   = 8'h02;
    localparam logic [7:0] P_TEST  = 8'h04;
    localparam logic [7:0] P_HALT  = 8'h08;
    localparam logic [7:0] P_CLEAR = 8'h10;
    localparam logic [7:0] P_ABORT = 8'h20;
    localparam logic [7:0] P_DONE  = 8'h40;
    localparam logic [7:0] P_MDONE = 8'h80;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       request_clear_mem = 1'b0, go_step_tck = 1'b0, go_step_sxr = 1'b0;
    logic       go_step_test = 1'b0, test_halt = 1'b0, test_abort = 1'b0;
    logic       mem_clear_done = 1'b0, exec_done = 1'b0, exec_idle = 1'b0;
    logic       mem_clear_req, exec_req, exec_halt, exec_abort;
    logic       step_done, cmd_rejected, busy, timeout_err;
    logic [1:0] exec_mode;
    logic [2:0] state_o;
    logic [7:0] step_count;
    logic [20:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign outs = {mem_clear_req, exec_req, exec_mode, exec_halt, exec_abort, step_done,
                   cmd_rejected, busy, state_o, step_count, timeout_err};

    step_controller #(.STEP_CNT_W(8), .WDOG_W(16), .WDOG_LIMIT(20)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .request_clear_mem (request_clear_mem),
        .go_step_tck       (go_step_tck),
        .go_step_sxr       (go_step_sxr),
        .go_step_test      (go_step_test),
        .test_halt         (test_halt),
        .test_abort        (test_abort),
        .mem_clear_req     (mem_clear_req),
        .mem_clear_done    (mem_clear_done),
        .exec_req          (exec_req),
        .exec_mode         (exec_mode),
        .exec_halt         (exec_halt),
        .exec_abort        (exec_abort),
        .exec_done         (exec_done),
        .exec_idle         (exec_idle),
        .step_done         (step_done),
        .cmd_rejected      (cmd_rejected),
        .busy              (busy),
        .state_o           (state_o),
        .step_count        (step_count),
        .timeout_err       (timeout_err)
    );

    // Drive a one-cycle pulse set (from a negedge), return at the next negedge
    task automatic pulse(input logic [7:0] v);
        {mem_clear_done, exec_done, test_abort, request_clear_mem,
         test_halt, go_step_test, go_step_sxr, go_step_tck} = v;
        @(negedge clk);
        {mem_clear_done, exec_done, test_abort, request_clear_mem,
         test_halt, go_step_test, go_step_sxr, go_step_tck} = 8'h00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++; if (outs !== 21'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        repeat (2) @(negedge clk);
        checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tck_step();
        pulse(P_TCK);
        checks++; if (exec_req !== 1'b1) begin errors++; $display("FAIL tck_req: got %b expected 1", exec_req); end
        checks++; if (exec_mode !== 2'd0) begin errors++; $display("FAIL tck_mode: got %0d expected 0", exec_mode); end
        checks++; if (busy !== 1'b1 || state_o !== 3'd2) begin errors++; $display("FAIL tck_busy: got busy=%b state=%0d expected 1/2", busy, state_o); end
        repeat (4) @(negedge clk);
        checks++; if (exec_req !== 1'b1 || step_done !== 1'b0) begin errors++; $display("FAIL tck_hold: got req=%b done=%b expected 1/0", exec_req, step_done); end
        pulse(P_DONE);
        checks++; if (step_done !== 1'b1) begin errors++; $display("FAIL tck_step_done: got %b expected 1", step_done); end
        checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL tck_count: got %0d expected 1", step_count); end
        checks++; if (state_o !== 3'd0 || exec_req !== 1'b0) begin errors++; $display("FAIL tck_idle: got state=%0d req=%b expected 0/0", state_o, exec_req); end
        @(negedge clk);
        checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL tck_done_pulse: got %b expected 0", step_done); end
    endtask

    task automatic test_halt_resume();
        pulse(P_TEST);
        checks++; if (state_o !== 3'd2 || exec_mode !== 2'd2) begin errors++; $display("FAIL hr_start: got state=%0d mode=%0d expected 2/2", state_o, exec_mode); end
        pulse(P_HALT);
        checks++; if (state_o !== 3'd3 || exec_halt !== 1'b1 || exec_req !== 1'b1) begin errors++; $display("FAIL hr_halted: got state=%0d halt=%b req=%b expected 3/1/1", state_o, exec_halt, exec_req); end
        pulse(P_TCK);
        checks++; if (cmd_rejected !== 1'b1 || state_o !== 3'd3) begin errors++; $display("FAIL hr_reject_tck: got rej=%b state=%0d expected 1/3", cmd_rejected, state_o); end
        pulse(P_TEST);
        checks++; if (exec_halt !== 1'b0 || state_o !== 3'd2 || cmd_rejected !== 1'b0) begin errors++; $display("FAIL hr_resume: got halt=%b state=%0d rej=%b expected 0/2/0", exec_halt, state_o, cmd_rejected); end
        pulse(P_DONE);
        checks++; if (step_done !== 1'b1 || step_count !== 8'd2) begin errors++; $display("FAIL hr_done: got done=%b count=%0d expected 1/2", step_done, step_count); end
    endtask

    task automatic test_reject();
        pulse(P_HALT);
        checks++; if (cmd_rejected !== 1'b1 || state_o !== 3'd0) begin errors++; $display("FAIL rej_idle_halt: got rej=%b state=%0d expected 1/0", cmd_rejected, state_o); end
        pulse(P_SXR);
        checks++; if (state_o !== 3'd2 || exec_mode !== 2'd1) begin errors++; $display("FAIL rej_sxr_start: got state=%0d mode=%0d expected 2/1", state_o, exec_mode); end
        pulse(P_HALT);
        checks++; if (cmd_rejected !== 1'b1 || state_o !== 3'd2 || exec_halt !== 1'b0) begin errors++; $display("FAIL rej_sxr_halt: got rej=%b state=%0d halt=%b expected 1/2/0", cmd_rejected, state_o, exec_halt); end
        pulse(P_DONE);
        checks++; if (step_count !== 8'd3) begin errors++; $display("FAIL rej_count3: got %0d expected 3", step_count); end
        pulse(P_TEST);
        pulse(P_SXR);
        checks++; if (cmd_rejected !== 1'b1 || exec_mode !== 2'd2 || state_o !== 3'd2) begin errors++; $display("FAIL rej_exec_sxr: got rej=%b mode=%0d state=%0d expected 1/2/2", cmd_rejected, exec_mode, state_o); end
        @(negedge clk);
        checks++; if (cmd_rejected !== 1'b0) begin errors++; $display("FAIL rej_pulse_width: got %b expected 0", cmd_rejected); end
        pulse(P_DONE);
        checks++; if (step_count !== 8'd4) begin errors++; $display("FAIL rej_count4: got %0d expected 4", step_count); end
    endtask

    task automatic test_clear_abort();
        pulse(P_TEST);
        pulse(P_CLEAR | P_ABORT);
        checks++; if (exec_abort !== 1'b1 || state_o !== 3'd4 || exec_req !== 1'b0) begin errors++; $display("FAIL ca_abort: got abort=%b state=%0d req=%b expected 1/4/0", exec_abort, state_o, exec_req); end
        pulse(P_DONE);
        checks++; if (step_done !== 1'b0 || state_o !== 3'd4) begin errors++; $display("FAIL ca_late_done: got done=%b state=%0d expected 0/4", step_done, state_o); end
        @(negedge clk);
        exec_idle = 1'b1;
        @(negedge clk);
        exec_idle = 1'b0;
        checks++; if (state_o !== 3'd1 || mem_clear_req !== 1'b1 || exec_abort !== 1'b0) begin errors++; $display("FAIL ca_to_clear: got state=%0d mreq=%b abort=%b expected 1/1/0", state_o, mem_clear_req, exec_abort); end
        checks++; if (step_count !== 8'd0) begin errors++; $display("FAIL ca_count_cleared: got %0d expected 0", step_count); end
        pulse(P_ABORT);
        checks++; if (state_o !== 3'd1 || cmd_rejected !== 1'b0 || mem_clear_req !== 1'b1) begin errors++; $display("FAIL ca_abort_in_clear: got state=%0d rej=%b mreq=%b expected 1/0/1", state_o, cmd_rejected, mem_clear_req); end
        pulse(P_TCK);
        checks++; if (cmd_rejected !== 1'b1 || state_o !== 3'd1) begin errors++; $display("FAIL ca_tck_in_clear: got rej=%b state=%0d expected 1/1", cmd_rejected, state_o); end
        pulse(P_MDONE);
        checks++; if (state_o !== 3'd0 || mem_clear_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ca_clear_done: got state=%0d mreq=%b busy=%b expected 0/0/0", state_o, mem_clear_req, busy); end
    endtask

    task automatic test_priority();
        pulse(P_TCK | P_TEST);
        checks++; if (exec_mode !== 2'd2 || state_o !== 3'd2) begin errors++; $display("FAIL pri_test_over_tck: got mode=%0d state=%0d expected 2/2", exec_mode, state_o); end
        pulse(P_DONE);
        checks++; if (step_count !== 8'd1) begin errors++; $display("FAIL pri_count: got %0d expected 1", step_count); end
        pulse(P_ABORT);
        checks++; if (state_o !== 3'd0 || cmd_rejected !== 1'b0) begin errors++; $display("FAIL pri_idle_abort: got state=%0d rej=%b expected 0/0", state_o, cmd_rejected); end
        pulse(P_SXR);
        pulse(P_ABORT | P_TCK);
        checks++; if (state_o !== 3'd4 || exec_abort !== 1'b1) begin errors++; $display("FAIL pri_abort_wins: got state=%0d abort=%b expected 4/1", state_o, exec_abort); end
        exec_idle = 1'b1;
        @(negedge clk);
        exec_idle = 1'b0;
        checks++; if (state_o !== 3'd0 || mem_clear_req !== 1'b0 || exec_abort !== 1'b0) begin errors++; $display("FAIL pri_abort_idle: got state=%0d mreq=%b abort=%b expected 0/0/0", state_o, mem_clear_req, exec_abort); end
        pulse(P_CLEAR | P_ABORT);
        checks++; if (state_o !== 3'd1 || mem_clear_req !== 1'b1 || step_count !== 8'd0) begin errors++; $display("FAIL pri_idle_clear_abort: got state=%0d mreq=%b count=%0d expected 1/1/0", state_o, mem_clear_req, step_count); end
        pulse(P_MDONE);
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 255; i++) begin
            pulse(P_TCK);
            pulse(P_DONE);
        end
        checks++; if (step_count !== 8'hFF) begin errors++; $display("FAIL wrap_max: got %0d expected 255", step_count); end
        pulse(P_TCK);
        pulse(P_DONE);
        checks++; if (step_count !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", step_count); end
    endtask

    task automatic test_reset_midhandshake();
        pulse(P_TEST);
        pulse(P_HALT);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (outs !== 21'd0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (state_o !== 3'd0 || step_done !== 1'b0) begin errors++; $display("FAIL midreset_after: got state=%0d done=%b expected 0/0", state_o, step_done); end
    endtask

`ifdef STEP_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        pulse(P_TEST);
        repeat (19) @(negedge clk);
        checks++; if (state_o !== 3'd2 || timeout_err !== 1'b0) begin errors++; $display("FAIL wd_before: got state=%0d to=%b expected 2/0", state_o, timeout_err); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b1 || state_o !== 3'd4 || exec_req !== 1'b0) begin errors++; $display("FAIL wd_expire: got to=%b state=%0d req=%b expected 1/4/0", timeout_err, state_o, exec_req); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (outs !== 21'd0) begin errors++; $display("FAIL wd_reset: got %h expected 0", outs); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_tck_step();
        test_halt_resume();
        test_reject();
        test_clear_abort();
        test_priority();
        test_count_wrap();
        test_reset_midhandshake();
`ifdef STEP_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
